// File: rtl/pipe_ctrl_if.sv
// Handshake bundle between the pipeline sequencer and the stages/PC unit.
// Master drives stall requests and exception commits; slave is pipe_ctrl.
interface pipe_ctrl_if;
   logic        stallreq_id_i;
   logic        stallreq_ex_i;
   logic        stallreq_mem_i;
   logic        except_valid_i;
   logic        except_eret_i;
   logic [4:0]  except_code_i;
   logic [31:0] epc_i;
   logic [5:0]  stall_o;
   logic        flush_o;
   logic [31:0] except_addr_o;
   logic        except_pc_o;
   logic [4:0]  cause_o;
   logic        timeout_o;
   logic        busy_o;

   modport master (
      output stallreq_id_i, stallreq_ex_i, stallreq_mem_i,
      output except_valid_i, except_eret_i, except_code_i, epc_i,
      input  stall_o, flush_o, except_addr_o, except_pc_o,
      input  cause_o, timeout_o, busy_o
   );

   modport slave (
      input  stallreq_id_i, stallreq_ex_i, stallreq_mem_i,
      input  except_valid_i, except_eret_i, except_code_i, epc_i,
      output stall_o, flush_o, except_addr_o, except_pc_o,
      output cause_o, timeout_o, busy_o
   );
endinterface

// File: rtl/pipe_ctrl.sv
// Pipeline sequencer: stall merge, exception/ERET flush+refill sequencing,
// and a stall watchdog that turns a hung stall into a vectored exception.
module pipe_ctrl #(
   parameter logic [31:0] EXC_VECTOR    = 32'h0000_0020,
   parameter int          STALL_TIMEOUT = 256,
   parameter int          CNT_W         = 9,
   parameter int          REFILL_CYCLES = 2,
   parameter logic [4:0]  TIMEOUT_CODE  = 5'h1F
) (
   input logic       clk,
   input logic       rst,
   pipe_ctrl_if.slave bus
);

   localparam int RW = (REFILL_CYCLES < 2) ? 1 : $clog2(REFILL_CYCLES + 1);
   localparam logic [RW-1:0] RLOAD = RW'(REFILL_CYCLES);
   localparam bit WD_EN = (STALL_TIMEOUT != 0);
   localparam logic [CNT_W-1:0] WD_LAST =
      CNT_W'(WD_EN ? STALL_TIMEOUT - 1 : 0);

   typedef enum logic [1:0] {RUN, HOLD, FLUSH, REFILL} state_e;

   state_e            state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [RW-1:0]     rcnt_q, rcnt_d;
   logic [31:0]       addr_q, addr_d;
   logic              pc_q, pc_d;
   logic [4:0]        cause_q, cause_d;
   logic              tmo_q, tmo_d;
   logic              req;
   logic [5:0]        stall;

   assign req = bus.stallreq_id_i | bus.stallreq_ex_i | bus.stallreq_mem_i;

   always_comb begin
      stall = 6'b000000;
      if (state_q != FLUSH) begin
         if (bus.stallreq_mem_i)     stall = 6'b011111;
         else if (bus.stallreq_ex_i) stall = 6'b001111;
         else if (bus.stallreq_id_i) stall = 6'b000111;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      rcnt_d  = rcnt_q;
      addr_d  = addr_q;
      pc_d    = pc_q;
      cause_d = cause_q;
      tmo_d   = 1'b0;
      case (state_q)
         RUN, HOLD: begin
            if (bus.except_valid_i) begin
               state_d = FLUSH;
               cnt_d   = '0;
               addr_d  = bus.except_eret_i ? bus.epc_i : EXC_VECTOR;
               pc_d    = ~bus.except_eret_i;
               cause_d = bus.except_code_i;
            end else if (!req) begin
               state_d = RUN;
               cnt_d   = '0;
            end else if (state_q == RUN) begin
               state_d = HOLD;
               cnt_d   = CNT_W'(1);
            end else if (WD_EN && cnt_q == WD_LAST) begin
               state_d = FLUSH;
               cnt_d   = '0;
               addr_d  = EXC_VECTOR;
               pc_d    = 1'b1;
               cause_d = TIMEOUT_CODE;
               tmo_d   = 1'b1;
            end else if (cnt_q != {CNT_W{1'b1}}) begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         FLUSH: begin
            state_d = REFILL;
            rcnt_d  = RLOAD;
         end
         REFILL: begin
            // Refill only advances on cycles where bubbles actually move.
            if (stall == 6'b000000) begin
               if (rcnt_q <= RW'(1)) begin
                  state_d = RUN;
                  rcnt_d  = '0;
               end else begin
                  rcnt_d = rcnt_q - RW'(1);
               end
            end
         end
         default: state_d = RUN;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q <= RUN;
         cnt_q   <= '0;
         rcnt_q  <= '0;
         addr_q  <= '0;
         pc_q    <= 1'b0;
         cause_q <= '0;
         tmo_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         rcnt_q  <= rcnt_d;
         addr_q  <= addr_d;
         pc_q    <= pc_d;
         cause_q <= cause_d;
         tmo_q   <= tmo_d;
      end
   end

   assign bus.stall_o       = stall;
   assign bus.flush_o       = (state_q == FLUSH);
   assign bus.busy_o        = (state_q == FLUSH) || (state_q == REFILL);
   assign bus.except_addr_o = addr_q;
   assign bus.except_pc_o   = pc_q;
   assign bus.cause_o       = cause_q;
   assign bus.timeout_o     = tmo_q;

endmodule

// File: doc/pipe_ctrl.md
Name: pipe_ctrl

Overview:
- Central pipeline sequencer for the 5-stage MIPS core.
- Merges per-stage stall requests into a per-stage stall vector.
- Sequences exception/ERET entry: one-cycle flush, then a bounded refill window.
- Supplies flush_i, except_addr_i and except_pc_i to the PC unit, and runs a stall watchdog that converts a hung stall into an exception.

Parameters:
- EXC_VECTOR, 32'h0000_0020, exception handler entry address.
- STALL_TIMEOUT, 256, consecutive stalled cycles before the watchdog fires; 0 disables the watchdog.
- CNT_W, 9, width of the stall counter; must hold STALL_TIMEOUT.
- REFILL_CYCLES, 2, unstalled cycles spent in REFILL after a flush; minimum 1.
- TIMEOUT_CODE, 5'h1F, cause code reported on watchdog expiry.

Ports:
- clk, in, 1, clock; all state updates on the rising edge.
- rst, in, 1, synchronous active-low reset.
- stallreq_id_i, in, 1, ID stage requests a stall (load-use).
- stallreq_ex_i, in, 1, EX stage requests a stall (mul/div busy).
- stallreq_mem_i, in, 1, MEM stage requests a stall (memory wait).
- except_valid_i, in, 1, MEM stage commits an exception or ERET this cycle.
- except_eret_i, in, 1, qualifies except_valid_i as ERET.
- except_code_i, in, 5, cause code; valid with except_valid_i.
- epc_i, in, 32, ERET return address from CP0.
- stall_o, out, 6, per-stage stall: bit0 PC, bit1 IF, bit2 ID, bit3 EX, bit4 MEM, bit5 WB.
- flush_o, out, 1, pipeline flush; drives the PC unit's flush_i.
- except_addr_o, out, 32, redirect target; drives except_addr_i.
- except_pc_o, out, 1, 1 = vectored entry, 0 = ERET; drives except_pc_i.
- cause_o, out, 5, latched cause of the last redirect.
- timeout_o, out, 1, one-cycle pulse when the watchdog fires.
- busy_o, out, 1, high in FLUSH or REFILL.

Behaviour:
- Reset (rst==0 at an edge) has priority over everything, including mid-flush or mid-refill.
- Reset values: state RUN, stall counter 0, refill counter 0, stall_o 0, flush_o 0, except_addr_o 0, except_pc_o 0, cause_o 0, timeout_o 0, busy_o 0.

Stall vector:
- Combinational, same cycle as the request.
- Priority MEM > EX > ID:
  - stallreq_mem_i gives 6'b011111.
  - else stallreq_ex_i gives 6'b001111.
  - else stallreq_id_i gives 6'b000111.
  - else 6'b000000.
- Forced to 0 in FLUSH.

States (2-bit): RUN, HOLD, FLUSH, REFILL.

RUN:
- except_valid_i -> FLUSH.
- else any stall request -> HOLD, with the stall counter loaded to 1.
- else stay in RUN.

HOLD:
- except_valid_i -> FLUSH; an exception beats a stall.
- else no stall request -> RUN, counter cleared.
- else if STALL_TIMEOUT!=0 and counter == STALL_TIMEOUT-1 -> FLUSH as watchdog: cause TIMEOUT_CODE, vectored, timeout_o=1 next cycle for exactly one cycle.
- else counter increments; it saturates and never wraps.

Latch on entering FLUSH (same edge as the transition):
- except_addr_o <= except_eret_i ? epc_i : EXC_VECTOR.
- except_pc_o <= ~except_eret_i.
- cause_o <= except_code_i.
- Watchdog entry latches EXC_VECTOR, except_pc_o=1, cause TIMEOUT_CODE.

FLUSH:
- Lasts exactly one cycle; flush_o=1 only here, so it is registered and state-decoded.
- except_valid_i is ignored.
- -> REFILL, refill counter loaded with REFILL_CYCLES.

REFILL:
- Stall requests are honoured in stall_o.
- Refill counter decrements only on cycles where stall_o==0.
- At count 1 with no stall -> RUN.
- except_valid_i is ignored; upstream stages carry only bubbles.

Other rules:
- except_addr_o, except_pc_o and cause_o hold their values until the next FLUSH entry.
- busy_o is decoded from state.
- Simultaneous stall request and exception in RUN or HOLD: FLUSH is taken, and stall_o still reflects the requests for that cycle.

Test Plan:
- Reset then idle with no requests -> stall_o=0, flush_o=0, except_addr_o=0, state RUN.
- stallreq_ex_i=1 for 3 cycles -> stall_o=6'b001111 in those same 3 cycles; with stallreq_mem_i also high in cycle 2 -> 6'b011111 that cycle; no flush.
- except_valid_i=1, eret=0, code=5'h0C in RUN -> next cycle flush_o=1 for exactly one cycle, except_addr_o=32'h20, except_pc_o=1, cause_o=0C; busy_o high for 3 cycles (FLUSH + 2 REFILL).
- except_valid_i=1, eret=1, epc_i=32'h0000_1234 during HOLD -> FLUSH, except_addr_o=32'h1234, except_pc_o=0.
- STALL_TIMEOUT=4 with stallreq_mem_i held high -> timeout_o pulses one cycle after the 4th stalled cycle, flush_o=1 that same cycle, cause_o=1F.
- rst low during REFILL -> next cycle state RUN, all outputs at reset values; a stall request in REFILL -> refill extends by the number of stalled cycles.
